cb_udn_reload: RTL and testbench
================================

# cb_udn_reload

Parametrised synchronous up/down counter, WIDTH bits, with synchronous clear and preset, parallel load, count enable, and carry-in/carry-out cascade. It is the next generation of the fixed-width down counter macros in the behavioural macro library. Over that family it adds run-time direction selection, a registered wrap pulse and an optional programmable auto-reload period. Instances chain through CAI/CAO to build wider or multi-stage timers.

## Interface
- WIDTH, default 8: counter width in bits (≥2).
- RLD_INIT, default all ones: reset value of the reload register; only meaningful with CB_AUTORELOAD_EN.

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- CD  in  1  reset; synchronous, active-high. Drives Q=0, WRAP=0 and reload register=RLD_INIT.
- SD  in  1  synchronous preset: Q=all ones.
- LD  in  1  synchronous parallel load: Q=D.
- D  in  WIDTH  load data.
- EN  in  1  count enable.
- CAI  in  1  carry/borrow in from the lower stage.
- UP  in  1  direction: 1=increment, 0=decrement. Sampled every cycle.
- RLD_WE  in  1  reload register write strobe (macro only).
- RLD  in  WIDTH  reload value (macro only).
- Q  out  WIDTH  counter value, registered.
- CAO  out  1  carry/borrow out, combinational.
- WRAP  out  1  registered one-cycle pulse after a terminal step.

## Operation
- Priority per edge: CD > SD > LD > count (EN && CAI) > hold.
- Terminal value: all ones when UP=1; zero when UP=0.
- Count step: Q ± 1 modulo 2^WIDTH.
- Terminal step: a count step taken while Q equals the terminal value for the current UP.
- CAO = CAI && EN && (Q == terminal for current UP).
  - Not gated by CD, SD or LD, so a chained stage sharing those controls behaves consistently.
- WRAP is 1 in the cycle after a terminal step and 0 otherwise.
  - SD, LD and CD never assert WRAP.
  - CD clears WRAP.
  - An LD in the cycle after a terminal step does not cancel the pending WRAP pulse.
- Direction change: the new UP value takes effect at the same edge, and the terminal value is evaluated with that same UP. No pipeline and no dead cycle.
- A disabled cycle (EN=0 or CAI=0) holds Q and leaves CAO at 0.

## Timing
- Q: 1-cycle latency from CD/SD/LD/count inputs.
- CAO: zero-latency, combinational from Q, CAI, EN and UP.
- WRAP: registered; asserted exactly one cycle after the terminal step.
- Reset: asserting CD in any cycle, including mid-count or mid-reload, gives Q=0, WRAP=0 and reload register=RLD_INIT at the next edge.
- Cascade: the combinational carry path is CAI→CAO, one gate level per stage, and chain length is bounded only by the timing closure of that path.

## Configuration
- Macro: CB_AUTORELOAD_EN.
- Defined:
  - RLD_WE and RLD ports and a WIDTH-bit reload register exist.
  - A terminal step loads Q with the reload register instead of wrapping, in both directions. The down-count period becomes reload value + 1.
  - RLD_WE writes RLD into the reload register.
  - If RLD_WE and a terminal step fall on the same edge, Q takes the old reload value; the new value applies from the following cycle.
  - LD, SD and CD keep priority over the reload.
- Undefined:
  - The ports and the register are absent.
  - A terminal step wraps modulo 2^WIDTH.

## Structure
- Shared package cb_pkg: all-ones constant function, direction enum (CB_DN=0, CB_UP=1).
- One sub-module, cb_term_det: combinational terminal-value detect (Q, UP) → term.
  - It feeds both CAO and the next-state and WRAP logic, so both see one definition of "terminal".
- Counter register, WRAP register and reload register all live in the top module.

## Test plan
- Reset and preset (WIDTH=8): CD=1 for one edge gives Q=0x00 and WRAP=0. Then SD=1 gives Q=0xFF.
- Down count: LD with D=0x02, then EN=CAI=1, UP=0.
  - Q sequence 0x02, 0x01, 0x00, 0xFF.
  - CAO=1 only while Q=0x00.
  - WRAP=1 only in the cycle where Q=0xFF.
- Up count with a direction flip:
  - From Q=0xFE with UP=1: Q goes to 0xFF (CAO=1 while Q=0xFF), then 0x00, and WRAP pulses.
  - Then UP=0: Q goes 0x00 → 0xFF, CAO=1 in the 0x00 cycle, and WRAP pulses again.
- Priority with D=0x5A:
  - CD, SD, LD and EN all high gives Q=0x00.
  - SD and LD high gives 0xFF.
  - LD and EN high gives 0x5A.
  - CAI=0 holds Q with CAO=0.
- Cascade: two WIDTH=4 instances, with low CAO driving high CAI. An up count from 0x0F gives 0x10, and the high CAO asserts only at 0xFF.
- CB_AUTORELOAD_EN: write RLD=0x05, then count down from 0x00.
  - Q=0x05, then 0x04 … 0x00.
  - At the terminal edge, apply RLD_WE with RLD=0x09: Q=0x05, and the next wrap gives 0x09.

Source files
------------

// File: rtl/cb_pkg.sv
// cb_pkg: shared definitions for the cb_* counter family.
//   cb_dir_e     - count direction (CB_DN = 0, CB_UP = 1)
//   cb_all_ones  - constant function giving an all-ones value of a given width
//                  (right-aligned in a CB_MAX_WIDTH-bit vector; callers cast
//                  it down to their own width).
package cb_pkg;

    typedef enum logic {
        CB_DN = 1'b0,
        CB_UP = 1'b1
    } cb_dir_e;

    localparam int CB_MAX_WIDTH = 64;

    function automatic logic [CB_MAX_WIDTH-1:0] cb_all_ones(input int width);
        return {CB_MAX_WIDTH{1'b1}} >> (CB_MAX_WIDTH - width);
    endfunction

endpackage

// File: rtl/cb_term_det.sv
// cb_term_det: combinational terminal-value detector.
// Terminal value is all ones when counting up and zero when counting down.
// Both the cascade output and the next-state/WRAP logic of the counter use
// this single block, so they cannot disagree about what "terminal" means.
// Ports:
//   q     in  WIDTH  current counter value
//   dir   in  1      count direction (cb_dir_e)
//   term  out 1      q equals the terminal value for dir
module cb_term_det
    import cb_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q,
    input  cb_dir_e          dir,
    output logic             term
);

    localparam logic [WIDTH-1:0] ONES = WIDTH'(cb_all_ones(WIDTH));

    always_comb begin
        term = 1'b0;
        if (dir == CB_UP) begin
            term = (q == ONES);
        end else begin
            term = (q == '0);
        end
    end

endmodule

// File: rtl/cb_udn_reload.sv
// cb_udn_reload: WIDTH-bit synchronous up/down counter with synchronous
// clear (CD) and preset (SD), parallel load (LD), count enable (EN) and a
// carry/borrow cascade (CAI -> CAO). WRAP is a registered one-cycle pulse
// following every terminal step.
//
// Optional feature, macro CB_AUTORELOAD_EN: adds a reload register (written
// through RLD_WE/RLD, reset to RLD_INIT). A terminal step then loads Q from
// that register instead of wrapping, in either direction.
//
// Ports:
//   CLK     in  1      clock, rising edge
//   CD      in  1      synchronous active-high reset (Q=0, WRAP=0, reload=RLD_INIT)
//   SD      in  1      synchronous preset, Q = all ones
//   LD      in  1      synchronous load, Q = D
//   D       in  WIDTH  load data
//   EN      in  1      count enable
//   CAI     in  1      carry/borrow in from the lower stage
//   UP      in  1      1 = increment, 0 = decrement (takes effect this edge)
//   RLD_WE  in  1      reload register write strobe (CB_AUTORELOAD_EN only)
//   RLD     in  WIDTH  reload value                (CB_AUTORELOAD_EN only)
//   Q       out WIDTH  counter value, registered
//   CAO     out 1      carry/borrow out, combinational
//   WRAP    out 1      registered pulse, one cycle after a terminal step
//
// Edge priority: CD > SD > LD > count (EN && CAI) > hold.
module cb_udn_reload
    import cb_pkg::*;
#(
    parameter int WIDTH = 8
`ifdef CB_AUTORELOAD_EN
    ,
    parameter logic [WIDTH-1:0] RLD_INIT = '1
`endif
) (
    input  logic             CLK,
    input  logic             CD,
    input  logic             SD,
    input  logic             LD,
    input  logic [WIDTH-1:0] D,
    input  logic             EN,
    input  logic             CAI,
    input  logic             UP,
`ifdef CB_AUTORELOAD_EN
    input  logic             RLD_WE,
    input  logic [WIDTH-1:0] RLD,
`endif
    output logic [WIDTH-1:0] Q,
    output logic             CAO,
    output logic             WRAP
);

    localparam logic [WIDTH-1:0] ONES = WIDTH'(cb_all_ones(WIDTH));

    cb_dir_e          dir;
    logic             term;
    logic             step;
    logic             terminal_step;
    logic [WIDTH-1:0] q_next;

`ifdef CB_AUTORELOAD_EN
    logic [WIDTH-1:0] rld_q;
`endif

    assign dir = cb_dir_e'(UP);

    cb_term_det #(
        .WIDTH(WIDTH)
    ) u_term_det (
        .q   (Q),
        .dir (dir),
        .term(term)
    );

    assign step          = EN && CAI;
    assign terminal_step = step && term;

    // Deliberately not gated by CD/SD/LD: a chained stage sharing those
    // controls sees the same carry that this stage would have produced.
    assign CAO = terminal_step;

    always_comb begin
        q_next = Q;
        if (SD) begin
            q_next = ONES;
        end else if (LD) begin
            q_next = D;
        end else if (step) begin
            if (dir == CB_UP) begin
                q_next = Q + 1'b1;
            end else begin
                q_next = Q - 1'b1;
            end
`ifdef CB_AUTORELOAD_EN
            // Reload uses the register value from before this edge, so a
            // simultaneous RLD_WE only affects the following period.
            if (term) begin
                q_next = rld_q;
            end
`endif
        end
    end

    always_ff @(posedge CLK) begin
        if (CD) begin
            Q    <= '0;
            WRAP <= 1'b0;
        end else begin
            Q    <= q_next;
            // SD or LD override the count, so no terminal step is taken.
            WRAP <= terminal_step && !SD && !LD;
        end
    end

`ifdef CB_AUTORELOAD_EN
    always_ff @(posedge CLK) begin
        if (CD) begin
            rld_q <= RLD_INIT;
        end else if (RLD_WE) begin
            rld_q <= RLD;
        end
    end
`endif

endmodule

// File: tb/tb_cb_udn_reload.sv
// tb_cb_udn_reload: directed bench for cb_udn_reload. One 8-bit instance for
// the main scenarios, and two 4-bit instances chained CAO->CAI for the cascade.
// Inputs are driven 1 ns after the rising edge; outputs are sampled there too.
module tb_cb_udn_reload;

    logic       clk = 1'b0;
    logic       cd = 1'b0, sd = 1'b0, ld = 1'b0, en = 1'b0, cai = 1'b0, up = 1'b0;
    logic [7:0] d = 8'h00;
    logic       rld_we = 1'b0;
    logic [7:0] rld = 8'h00;
    logic [7:0] q;
    logic       cao, wrap;

    // cascade pair
    logic       c_cd = 1'b0, c_ld = 1'b0, c_en = 1'b0, c_cai = 1'b0, c_up = 1'b1;
    logic [7:0] c_d = 8'h00;
    logic [3:0] lo_q, hi_q;
    logic       lo_cao, hi_cao, lo_wrap, hi_wrap;

    int checks   = 0;
    int failures = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    cb_udn_reload #(.WIDTH(8)) dut (
        .CLK(clk), .CD(cd), .SD(sd), .LD(ld), .D(d), .EN(en), .CAI(cai), .UP(up),
`ifdef CB_AUTORELOAD_EN
        .RLD_WE(rld_we), .RLD(rld),
`endif
        .Q(q), .CAO(cao), .WRAP(wrap)
    );

    cb_udn_reload #(.WIDTH(4)) u_lo (
        .CLK(clk), .CD(c_cd), .SD(1'b0), .LD(c_ld), .D(c_d[3:0]), .EN(c_en), .CAI(c_cai), .UP(c_up),
`ifdef CB_AUTORELOAD_EN
        .RLD_WE(1'b0), .RLD(4'h0),
`endif
        .Q(lo_q), .CAO(lo_cao), .WRAP(lo_wrap)
    );

    cb_udn_reload #(.WIDTH(4)) u_hi (
        .CLK(clk), .CD(c_cd), .SD(1'b0), .LD(c_ld), .D(c_d[7:4]), .EN(c_en), .CAI(lo_cao), .UP(c_up),
`ifdef CB_AUTORELOAD_EN
        .RLD_WE(1'b0), .RLD(4'h0),
`endif
        .Q(hi_q), .CAO(hi_cao), .WRAP(hi_wrap)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        cd = 1'b1; sd = 1'b0; ld = 1'b0; en = 1'b1; cai = 1'b1; up = 1'b1;
        tick();
        checks++; if (q !== 8'h00) begin failures++; $display("FAIL reset_q got=%h exp=00", q); end
        checks++; if (wrap !== 1'b0) begin failures++; $display("FAIL reset_wrap got=%b exp=0", wrap); end
        cd = 1'b0; sd = 1'b1; en = 1'b0;
        tick();
        checks++; if (q !== 8'hFF) begin failures++; $display("FAIL preset_q got=%h exp=ff", q); end
        checks++; if (wrap !== 1'b0) begin failures++; $display("FAIL preset_wrap got=%b exp=0", wrap); end
        sd = 1'b0;
    endtask

    task automatic test_down_count();
        logic [2:0] exp_c;
        logic [2:0] exp_w;
        logic [7:0] e;
        ld = 1'b1; d = 8'h02; en = 1'b0; cai = 1'b1; up = 1'b0;
        tick();
        checks++; if (q !== 8'h02) begin failures++; $display("FAIL dn_load got=%h exp=02", q); end
        ld = 1'b0; en = 1'b1;
        #1;
        checks++; if (cao !== 1'b0) begin failures++; $display("FAIL dn_cao_02 got=%b exp=0", cao); end
        exp_q.push_back(8'h01); exp_q.push_back(8'h00); exp_q.push_back(8'hFF);
        exp_c = 3'b010;  // index 0..2: CAO high only at Q=00
        exp_w = 3'b100;  // WRAP high only at Q=FF
        for (int i = 0; i < 3; i++) begin
            tick();
            e = exp_q.pop_front();
            checks++; if (q !== e) begin failures++; $display("FAIL dn_q[%0d] got=%h exp=%h", i, q, e); end
            checks++; if (cao !== exp_c[i]) begin failures++; $display("FAIL dn_cao[%0d] got=%b exp=%b", i, cao, exp_c[i]); end
            checks++; if (wrap !== exp_w[i]) begin failures++; $display("FAIL dn_wrap[%0d] got=%b exp=%b", i, wrap, exp_w[i]); end
        end
        en = 1'b0;
        tick();
        checks++; if (q !== 8'hFF) begin failures++; $display("FAIL dn_hold got=%h exp=ff", q); end
        checks++; if (wrap !== 1'b0) begin failures++; $display("FAIL dn_wrap_end got=%b exp=0", wrap); end
    endtask

    task automatic test_up_flip();
        ld = 1'b1; d = 8'hFE; en = 1'b0; cai = 1'b1; up = 1'b1;
        tick();
        ld = 1'b0; en = 1'b1;
        #1;
        checks++; if (cao !== 1'b0) begin failures++; $display("FAIL up_cao_fe got=%b exp=0", cao); end
        tick();
        checks++; if (q !== 8'hFF) begin failures++; $display("FAIL up_q_ff got=%h exp=ff", q); end
        checks++; if (cao !== 1'b1) begin failures++; $display("FAIL up_cao_ff got=%b exp=1", cao); end
        checks++; if (wrap !== 1'b0) begin failures++; $display("FAIL up_wrap_ff got=%b exp=0", wrap); end
        tick();
        checks++; if (q !== 8'h00) begin failures++; $display("FAIL up_q_00 got=%h exp=00", q); end
        checks++; if (wrap !== 1'b1) begin failures++; $display("FAIL up_wrap_00 got=%b exp=1", wrap); end
        checks++; if (cao !== 1'b0) begin failures++; $display("FAIL up_cao_00 got=%b exp=0", cao); end
        up = 1'b0;
        #1;
        checks++; if (cao !== 1'b1) begin failures++; $display("FAIL flip_cao got=%b exp=1", cao); end
        tick();
        checks++; if (q !== 8'hFF) begin failures++; $display("FAIL flip_q got=%h exp=ff", q); end
        checks++; if (wrap !== 1'b1) begin failures++; $display("FAIL flip_wrap got=%b exp=1", wrap); end
        en = 1'b0;
        tick();
        checks++; if (wrap !== 1'b0) begin failures++; $display("FAIL flip_wrap_end got=%b exp=0", wrap); end
    endtask

    task automatic test_priority();
        d = 8'h5A; up = 1'b0; cai = 1'b1;
        cd = 1'b1; sd = 1'b1; ld = 1'b1; en = 1'b1;
        tick();
        checks++; if (q !== 8'h00) begin failures++; $display("FAIL prio_cd got=%h exp=00", q); end
        cd = 1'b0;  // Q=00 and UP=0: a count here would be terminal, SD must win
        tick();
        checks++; if (q !== 8'hFF) begin failures++; $display("FAIL prio_sd got=%h exp=ff", q); end
        checks++; if (wrap !== 1'b0) begin failures++; $display("FAIL prio_sd_wrap got=%b exp=0", wrap); end
        sd = 1'b0;
        tick();
        checks++; if (q !== 8'h5A) begin failures++; $display("FAIL prio_ld got=%h exp=5a", q); end
        ld = 1'b0; cai = 1'b0;
        #1;
        checks++; if (cao !== 1'b0) begin failures++; $display("FAIL prio_cai0_cao got=%b exp=0", cao); end
        tick();
        checks++; if (q !== 8'h5A) begin failures++; $display("FAIL prio_cai0_hold got=%h exp=5a", q); end
        cai = 1'b1; en = 1'b0;
        tick();
        checks++; if (q !== 8'h5A) begin failures++; $display("FAIL prio_en0_hold got=%h exp=5a", q); end
    endtask

    task automatic test_back_to_back();
        // LD right after a terminal step: WRAP still shows the pulse.
        ld = 1'b1; d = 8'h00; en = 1'b0; cai = 1'b1; up = 1'b0;
        tick();
        ld = 1'b0; en = 1'b1;
        tick();
        ld = 1'b1; d = 8'h33;
        checks++; if (wrap !== 1'b1) begin failures++; $display("FAIL b2b_wrap got=%b exp=1", wrap); end
        tick();
        checks++; if (q !== 8'h33) begin failures++; $display("FAIL b2b_ld got=%h exp=33", q); end
        checks++; if (wrap !== 1'b0) begin failures++; $display("FAIL b2b_wrap_ld got=%b exp=0", wrap); end
        ld = 1'b0; en = 1'b0;
    endtask

    task automatic test_cascade();
        c_cd = 1'b1;
        tick();
        c_cd = 1'b0; c_ld = 1'b1; c_d = 8'h0F; c_up = 1'b1; c_cai = 1'b1;
        tick();
        c_ld = 1'b0; c_en = 1'b1;
        #1;
        checks++; if (lo_cao !== 1'b1) begin failures++; $display("FAIL cas_lo_cao got=%b exp=1", lo_cao); end
        checks++; if (hi_cao !== 1'b0) begin failures++; $display("FAIL cas_hi_cao_0f got=%b exp=0", hi_cao); end
        tick();
        checks++; if ({hi_q, lo_q} !== 8'h10) begin failures++; $display("FAIL cas_q_10 got=%h exp=10", {hi_q, lo_q}); end
        c_ld = 1'b1; c_d = 8'hFE; c_en = 1'b0;
        tick();
        c_ld = 1'b0; c_en = 1'b1;
        #1;
        checks++; if (hi_cao !== 1'b0) begin failures++; $display("FAIL cas_hi_cao_fe got=%b exp=0", hi_cao); end
        tick();
        checks++; if ({hi_q, lo_q} !== 8'hFF) begin failures++; $display("FAIL cas_q_ff got=%h exp=ff", {hi_q, lo_q}); end
        checks++; if (hi_cao !== 1'b1) begin failures++; $display("FAIL cas_hi_cao_ff got=%b exp=1", hi_cao); end
        tick();
        checks++; if ({hi_q, lo_q} !== 8'h00) begin failures++; $display("FAIL cas_q_00 got=%h exp=00", {hi_q, lo_q}); end
        checks++; if (hi_cao !== 1'b0) begin failures++; $display("FAIL cas_hi_cao_00 got=%b exp=0", hi_cao); end
        c_en = 1'b0;
    endtask

`ifdef CB_AUTORELOAD_EN
    task automatic test_autoreload();
        logic [7:0] e;
        cd = 1'b1; sd = 1'b0; ld = 1'b0; en = 1'b0; cai = 1'b1; up = 1'b0;
        tick();
        cd = 1'b0; rld_we = 1'b1; rld = 8'h05;
        tick();
        rld_we = 1'b0; ld = 1'b1; d = 8'h00;
        tick();
        ld = 1'b0; en = 1'b1;
        tick();
        checks++; if (q !== 8'h05) begin failures++; $display("FAIL rld_first got=%h exp=05", q); end
        checks++; if (wrap !== 1'b1) begin failures++; $display("FAIL rld_wrap1 got=%b exp=1", wrap); end
        for (int v = 4; v >= 0; v--) begin
            tick();
            e = 8'(v);
            checks++; if (q !== e) begin failures++; $display("FAIL rld_dn got=%h exp=%h", q, e); end
        end
        rld_we = 1'b1; rld = 8'h09;
        tick();
        rld_we = 1'b0;
        checks++; if (q !== 8'h05) begin failures++; $display("FAIL rld_old got=%h exp=05", q); end
        checks++; if (wrap !== 1'b1) begin failures++; $display("FAIL rld_wrap2 got=%b exp=1", wrap); end
        repeat (6) tick();
        checks++; if (q !== 8'h09) begin failures++; $display("FAIL rld_new got=%h exp=09", q); end
        en = 1'b0;
    endtask
`endif

    initial begin
        tick();
        test_reset();
        test_down_count();
        test_up_flip();
        test_priority();
        test_back_to_back();
        test_cascade();
`ifdef CB_AUTORELOAD_EN
        test_autoreload();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
